// File: rtl/al_enc_16to4_scanner_pkg.sv
// Shared types and helpers for the active-low 16-to-4 line scanner.
//   N_LINES  : default number of request lines
//   AW_LINES : index width derived from N_LINES
//   state_e  : scanner FSM states
//   popcount : number of set bits in a line vector, full AW_LINES+1 width
package al_enc_16to4_scanner_pkg;

  localparam int unsigned N_LINES  = 16;
  localparam int unsigned AW_LINES = $clog2(N_LINES);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Width is AW_LINES+1 so an all-set vector (N_LINES) does not wrap to 0.
  function automatic logic [AW_LINES:0] popcount(input logic [N_LINES-1:0] v);
    logic [AW_LINES:0] c;
    c = '0;
    for (int i = 0; i < int'(N_LINES); i++) begin
      c = c + (AW_LINES+1)'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/al_prio_enc_lsb.sv
// Combinational lowest-index-first priority encoder.
//   vec : input vector, active-high
//   idx : index of the lowest set bit of vec (0 when vec is empty)
//   any : vec has at least one set bit
module al_prio_enc_lsb #(
  parameter int unsigned N  = 16,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic [AW-1:0] idx,
  output logic          any
);

  // Scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) idx = AW'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/al_enc_16to4_scanner.sv
// Sequential active-low line encoder: snapshots N active-low request lines and
// emits the index of every asserted line over valid/ready, lowest first.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : capture enable, active-low
//   d          : request lines, active-low
//   ready      : consumer accepts a this cycle
//   a, valid   : current pending index and its qualifier
//   busy       : snapshot is being drained
//   cnt, multi : asserted-line count of the last capture, and cnt > 1
//   done       : one-cycle pulse after the last index of a snapshot is taken
module al_enc_16to4_scanner
  import al_enc_16to4_scanner_pkg::*;
#(
  parameter int unsigned N  = N_LINES,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  d,
  input  logic          ready,
  output logic [AW-1:0] a,
  output logic          valid,
  output logic          busy,
  output logic [AW:0]   cnt,
  output logic          multi,
  output logic          done
);

  state_e        state_q, state_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          multi_q, multi_d;
  logic          done_q, done_d;

  logic [N-1:0]  lines_c;
  logic [N-1:0]  pending_clr_c;
  logic [AW:0]   pop_cnt_c;
  logic [AW-1:0] enc_idx;
  logic          enc_any;
  logic          capture_c;
  logic          xfer_c;
  logic          last_c;

  al_prio_enc_lsb #(
    .N  (N),
    .AW (AW)
  ) u_enc (
    .vec (pending_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  assign lines_c       = ~d;
  assign pop_cnt_c     = (AW+1)'(popcount(lines_c));
  assign capture_c     = (state_q == IDLE) && !en && (lines_c != '0);
  // valid is always high in EMIT, so ready alone completes a transfer there.
  assign xfer_c        = (state_q == EMIT) && ready;
  assign pending_clr_c = pending_q & ~(N'(1) << enc_idx);
  assign last_c        = (pending_clr_c == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (capture_c)        state_d = EMIT;
      EMIT:    if (xfer_c && last_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; a is forced to 0 outside EMIT
  always_comb begin
    a     = '0;
    valid = 1'b0;
    busy  = 1'b0;
    if (state_q == EMIT) begin
      busy  = 1'b1;
      valid = enc_any;
      a     = enc_idx;
    end
  end

  // Snapshot, statistics and done pulse next-state
  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    multi_d   = multi_q;
    done_d    = 1'b0;
    if (capture_c) begin
      pending_d = lines_c;
      cnt_d     = pop_cnt_c;
      multi_d   = pop_cnt_c > (AW+1)'(1);
    end else if (xfer_c) begin
      pending_d = pending_clr_c;
      done_d    = last_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      multi_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      multi_q   <= multi_d;
      done_q    <= done_d;
    end
  end

  assign cnt   = cnt_q;
  assign multi = multi_q;
  assign done  = done_q;

endmodule

// File: tb/tb_al_enc_16to4_scanner.sv
// Self-checking bench for al_enc_16to4_scanner: table of snapshots drained
// through a scoreboard queue, plus hand-written stall/reset/back-to-back cases.
module tb_al_enc_16to4_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] d;
  logic        ready;
  logic [3:0]  a;
  logic        valid;
  logic        busy;
  logic [4:0]  cnt;
  logic        multi;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] exp_q[$];

  typedef struct {
    logic [15:0] d;
    logic [4:0]  cnt;
    logic        multi;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  al_enc_16to4_scanner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .d     (d),
    .ready (ready),
    .a     (a),
    .valid (valid),
    .busy  (busy),
    .cnt   (cnt),
    .multi (multi),
    .done  (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected index stream for an active-low snapshot, lowest line first.
  task automatic push_exp(input logic [15:0] dv);
    for (int i = 0; i < 16; i++) begin
      if (!dv[i]) exp_q.push_back(4'(i));
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the capture edge.
  task automatic capture(input logic [15:0] dv);
    en = 1'b0;
    d  = dv;
    push_exp(dv);
    @(negedge clk);
    en = 1'b1;
    d  = 16'hFFFF;
  endtask

  // Holds ready high, expects one index per cycle, then the done cycle.
  task automatic drain(input string tag, input logic [4:0] ecnt, input logic emulti);
    logic [3:0] e;
    ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " valid"}, 32'(valid), 32'd1);
      chk({tag, " a"}, 32'(a), 32'(e));
      @(negedge clk);
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " valid in done cycle"}, 32'(valid), 32'd0);
    chk({tag, " cnt"}, 32'(cnt), 32'(ecnt));
    chk({tag, " multi"}, 32'(multi), 32'(emulti));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{16'hFFFB, 5'd1,  1'b0};
    tbl[1] = '{16'h7FFE, 5'd2,  1'b1};
    tbl[2] = '{16'hFF0F, 5'd4,  1'b1};
    tbl[3] = '{16'h0000, 5'd16, 1'b1};
    tbl[4] = '{16'hAAAA, 5'd8,  1'b1};
    tbl[5] = '{16'h7FFF, 5'd1,  1'b0};

    // Reset state, then capture right after release
    rst_n = 1'b0;
    en    = 1'b0;
    d     = 16'h0000;
    ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset a",     32'(a),     32'd0);
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset busy",  32'(busy),  32'd0);
    chk("reset cnt",   32'(cnt),   32'd0);
    chk("reset multi", 32'(multi), 32'd0);
    chk("reset done",  32'(done),  32'd0);
    push_exp(16'h0000);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    d  = 16'hFFFF;
    chk("post-reset capture cnt", 32'(cnt), 32'd16);
    drain("post-reset all lines", 5'd16, 1'b1);
    @(negedge clk);

    // Table-driven snapshots
    for (int k = 0; k < 6; k++) begin
      capture(tbl[k].d);
      chk($sformatf("tbl%0d busy", k),  32'(busy),  32'd1);
      chk($sformatf("tbl%0d cnt", k),   32'(cnt),   32'(tbl[k].cnt));
      chk($sformatf("tbl%0d multi", k), 32'(multi), 32'(tbl[k].multi));
      drain($sformatf("tbl%0d", k), tbl[k].cnt, tbl[k].multi);
      @(negedge clk);
      chk($sformatf("tbl%0d done falls", k), 32'(done), 32'd0);
    end

    // Stall: a and valid held while ready is low
    ready = 1'b0;
    capture(16'hFF0F);
    for (int s = 0; s < 3; s++) begin
      chk("stall valid", 32'(valid), 32'd1);
      chk("stall a",     32'(a),     32'd4);
      @(negedge clk);
    end
    drain("stall release", 5'd4, 1'b1);
    @(negedge clk);

    // No capture: empty request with en low, then en high with requests
    en = 1'b0;
    d  = 16'hFFFF;
    repeat (2) begin
      @(negedge clk);
      chk("empty req valid", 32'(valid), 32'd0);
      chk("empty req busy",  32'(busy),  32'd0);
      chk("empty req cnt",   32'(cnt),   32'd4);
    end
    en = 1'b1;
    d  = 16'h0000;
    repeat (2) begin
      @(negedge clk);
      chk("en high valid", 32'(valid), 32'd0);
      chk("en high cnt",   32'(cnt),   32'd4);
    end
    d = 16'hFFFF;

    // d changes during EMIT are ignored
    ready = 1'b0;
    capture(16'hFFF0);
    en = 1'b0;
    d  = 16'h0000;
    repeat (2) @(negedge clk);
    chk("mid-emit a",   32'(a),   32'd0);
    chk("mid-emit cnt", 32'(cnt), 32'd4);
    en = 1'b1;
    d  = 16'hFFFF;
    drain("mid-emit d change", 5'd4, 1'b1);
    @(negedge clk);

    // Back-to-back: capture in the done cycle, one non-valid cycle between
    ready = 1'b1;
    capture(16'hFFF3);
    en = 1'b0;
    d  = 16'hBFFF;
    drain("b2b first", 5'd2, 1'b1);
    push_exp(16'hBFFF);
    @(negedge clk);
    en = 1'b1;
    d  = 16'hFFFF;
    chk("b2b second valid", 32'(valid), 32'd1);
    chk("b2b second a",     32'(a),     32'd14);
    chk("b2b done falls",   32'(done),  32'd0);
    drain("b2b second", 5'd1, 1'b0);
    @(negedge clk);

    // Reset mid-EMIT: immediate drop, snapshot discarded, no done
    capture(16'h00FF);
    @(negedge clk);
    chk("pre-reset a", 32'(a), 32'd9);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid reset valid", 32'(valid), 32'd0);
    chk("mid reset busy",  32'(busy),  32'd0);
    chk("mid reset a",     32'(a),     32'd0);
    chk("mid reset cnt",   32'(cnt),   32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("after reset done",  32'(done),  32'd0);
      chk("after reset valid", 32'(valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
